// File: rtl/io_stim_sequencer.sv
// Stimulus sequencer: replays a programmable (value, hold-cycles) table onto a
// switch/button-style bus, one-shot or looping, with abort.
module io_stim_sequencer #(
    parameter int                 WIDTH     = 32,
    parameter int                 DEPTH     = 16,
    parameter int                 CNT_W     = 32,
    parameter logic [WIDTH-1:0]   RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       cfg_we_i,
    input  logic [$clog2(DEPTH)-1:0]   cfg_addr_i,
    input  logic [WIDTH-1:0]           cfg_value_i,
    input  logic [CNT_W-1:0]           cfg_hold_i,
    input  logic [$clog2(DEPTH):0]     len_i,
    input  logic                       loop_i,
    input  logic                       start_i,
    input  logic                       stop_i,
    output logic [WIDTH-1:0]           stim_o,
    output logic                       stim_upd_o,
    output logic [$clog2(DEPTH)-1:0]   idx_o,
    output logic                       busy_o,
    output logic                       done_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic {ST_IDLE, ST_PLAY} state_t;

    logic [WIDTH-1:0] r_val  [DEPTH];
    logic [CNT_W-1:0] r_hold [DEPTH];

    state_t           r_state;
    logic [LW-1:0]    r_len;
    logic             r_loop;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_stim;
    logic [AW-1:0]    r_idx;
    logic             r_upd;
    logic             r_done;

    state_t           w_state_n;
    logic [LW-1:0]    w_len_n;
    logic             w_loop_n;
    logic [CNT_W-1:0] w_cnt_n;
    logic             w_load;
    logic [AW-1:0]    w_ld_idx;
    logic             w_done_n;
    logic             w_last;

    // A hold of 0 still shows the entry for one cycle: preload H'-1.
    function automatic logic [CNT_W-1:0] hold_m1(input logic [CNT_W-1:0] h);
        return (h == '0) ? '0 : h - CNT_W'(1);
    endfunction

    // NOTE: the table is plain storage with no reset, so it keeps its contents
    // across rst_i and maps onto RAM; only the control path is reset.
    always_ff @(posedge clk_i) begin
        if (cfg_we_i) begin
            r_val[cfg_addr_i]  <= cfg_value_i;
            r_hold[cfg_addr_i] <= cfg_hold_i;
        end
    end

    assign w_last = ({1'b0, r_idx} == (r_len - LW'(1)));

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_state_n = r_state;
        w_len_n   = r_len;
        w_loop_n  = r_loop;
        w_cnt_n   = r_cnt;
        w_load    = 1'b0;
        w_ld_idx  = '0;
        w_done_n  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start_i && !stop_i && (len_i != '0)) begin
                    w_state_n = ST_PLAY;
                    w_len_n   = (len_i > LW'(DEPTH)) ? LW'(DEPTH) : len_i;
                    w_loop_n  = loop_i;
                    w_load    = 1'b1;
                end
            end
            ST_PLAY: begin
                if (stop_i) begin
                    w_state_n = ST_IDLE;
                end else if (r_cnt != '0) begin
                    w_cnt_n = r_cnt - CNT_W'(1);
                end else if (w_last) begin
                    if (r_loop) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_n = ST_IDLE;
                        w_done_n  = 1'b1;
                    end
                end else begin
                    w_load   = 1'b1;
                    w_ld_idx = r_idx + AW'(1);
                end
            end
            default: w_state_n = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; the table read here sees old data on a same-cycle write.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_len   <= '0;
            r_loop  <= 1'b0;
            r_cnt   <= '0;
            r_stim  <= RESET_VAL;
            r_idx   <= '0;
            r_upd   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_len   <= w_len_n;
            r_loop  <= w_loop_n;
            r_upd   <= w_load;
            r_done  <= w_done_n;
            if (w_load) begin
                r_stim <= r_val[w_ld_idx];
                r_idx  <= w_ld_idx;
                r_cnt  <= hold_m1(r_hold[w_ld_idx]);
            end else begin
                r_cnt  <= w_cnt_n;
            end
        end
    end

    assign stim_o     = r_stim;
    assign stim_upd_o = r_upd;
    assign idx_o      = r_idx;
    assign busy_o     = (r_state == ST_PLAY);
    assign done_o     = r_done;

endmodule

// File: tb/tb_io_stim_sequencer.sv
// Directed bench for io_stim_sequencer: one-shot, loop, abort, hold/len edges,
// collisions and reset behaviour, checked with immediate assertions.
module tb_io_stim_sequencer;

    localparam int W  = 32;
    localparam int D  = 16;
    localparam int C  = 32;
    localparam int AW = 4;
    localparam int LW = 5;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          cfg_we_i;
    logic [AW-1:0] cfg_addr_i;
    logic [W-1:0]  cfg_value_i;
    logic [C-1:0]  cfg_hold_i;
    logic [LW-1:0] len_i;
    logic          loop_i;
    logic          start_i;
    logic          stop_i;
    logic [W-1:0]  stim_o;
    logic          stim_upd_o;
    logic [AW-1:0] idx_o;
    logic          busy_o;
    logic          done_o;

    int total = 0;
    int bad   = 0;

    io_stim_sequencer #(
        .WIDTH(W), .DEPTH(D), .CNT_W(C), .RESET_VAL('0)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .cfg_we_i   (cfg_we_i),
        .cfg_addr_i (cfg_addr_i),
        .cfg_value_i(cfg_value_i),
        .cfg_hold_i (cfg_hold_i),
        .len_i      (len_i),
        .loop_i     (loop_i),
        .start_i    (start_i),
        .stop_i     (stop_i),
        .stim_o     (stim_o),
        .stim_upd_o (stim_upd_o),
        .idx_o      (idx_o),
        .busy_o     (busy_o),
        .done_o     (done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk_i);
    endtask

    task automatic wr(input int addr, input logic [W-1:0] val, input logic [C-1:0] hold);
        cfg_we_i    = 1'b1;
        cfg_addr_i  = AW'(addr);
        cfg_value_i = val;
        cfg_hold_i  = hold;
        step();
        cfg_we_i    = 1'b0;
    endtask

    // Entry is expected for h consecutive cycles, with stim_upd_o only on the first.
    task automatic expect_entry(input string tag, input int idx, input logic [W-1:0] val, input int h);
        for (int c = 0; c < h; c++) begin
            check({tag, "_stim"}, 64'(stim_o), 64'(val));
            check({tag, "_idx"},  64'(idx_o), 64'(idx));
            check({tag, "_upd"},  64'(stim_upd_o), 64'(c == 0));
            check({tag, "_busy"}, 64'(busy_o), 64'd1);
            check({tag, "_done"}, 64'(done_o), 64'd0);
            step();
        end
    endtask

    task automatic start_play(input int len, input logic lp);
        len_i   = LW'(len);
        loop_i  = lp;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1; cfg_we_i = 1'b0; cfg_addr_i = '0; cfg_value_i = '0; cfg_hold_i = '0;
        len_i = '0; loop_i = 1'b0; start_i = 1'b0; stop_i = 1'b0;
        step(); step();
        check("rst_stim", 64'(stim_o), 64'd0);
        check("rst_idx",  64'(idx_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_upd",  64'(stim_upd_o), 64'd0);
        check("rst_done", 64'(done_o), 64'd0);
        rst_i = 1'b0;
        step();
        check("post_rst_busy", 64'(busy_o), 64'd0);

        wr(0, 32'h0000_0021, 4);
        wr(1, 32'h0111_1000, 6);
        wr(2, 32'h1833_4891, 2);

        // One-shot playback
        start_play(3, 1'b0);
        expect_entry("os0", 0, 32'h0000_0021, 4);
        expect_entry("os1", 1, 32'h0111_1000, 6);
        expect_entry("os2", 2, 32'h1833_4891, 2);
        check("os_done",  64'(done_o), 64'd1);
        check("os_busy",  64'(busy_o), 64'd0);
        check("os_stim",  64'(stim_o), 64'h1833_4891);
        check("os_idx",   64'(idx_o), 64'd2);
        check("os_upd",   64'(stim_upd_o), 64'd0);
        step();
        check("os_done2", 64'(done_o), 64'd0);
        check("os_stim2", 64'(stim_o), 64'h1833_4891);

        // Looping playback, then abort
        start_play(3, 1'b1);
        expect_entry("lp0", 0, 32'h0000_0021, 4);
        expect_entry("lp1", 1, 32'h0111_1000, 6);
        expect_entry("lp2", 2, 32'h1833_4891, 2);
        check("lp_wrap_stim", 64'(stim_o), 64'h21);
        check("lp_wrap_upd",  64'(stim_upd_o), 64'd1);
        check("lp_wrap_idx",  64'(idx_o), 64'd0);
        stop_i = 1'b1;
        step();
        stop_i = 1'b0;
        check("stop_busy", 64'(busy_o), 64'd0);
        check("stop_stim", 64'(stim_o), 64'h21);
        check("stop_idx",  64'(idx_o), 64'd0);
        check("stop_upd",  64'(stim_upd_o), 64'd0);
        check("stop_done", 64'(done_o), 64'd0);
        step();
        check("stop_done2", 64'(done_o), 64'd0);
        check("stop_busy2", 64'(busy_o), 64'd0);

        // start & stop together in IDLE: stop wins
        len_i = 5'd3; start_i = 1'b1; stop_i = 1'b1;
        step();
        start_i = 1'b0; stop_i = 1'b0;
        check("ss_busy", 64'(busy_o), 64'd0);
        check("ss_upd",  64'(stim_upd_o), 64'd0);
        check("ss_stim", 64'(stim_o), 64'h21);

        // len_i == 0: start ignored
        start_play(0, 1'b0);
        check("len0_busy", 64'(busy_o), 64'd0);
        check("len0_upd",  64'(stim_upd_o), 64'd0);
        step();
        check("len0_busy2", 64'(busy_o), 64'd0);
        check("len0_done",  64'(done_o), 64'd0);

        // Write to entry 1 in the cycle it is loaded: old data now, new data next pass
        start_play(3, 1'b1);
        for (int c = 0; c < 4; c++) begin
            check("col0_stim", 64'(stim_o), 64'h21);
            if (c == 3) begin
                cfg_we_i = 1'b1; cfg_addr_i = 4'd1; cfg_value_i = 32'hDEAD_BEEF; cfg_hold_i = 6;
            end
            step();
        end
        cfg_we_i = 1'b0;
        expect_entry("col1", 1, 32'h0111_1000, 6);
        expect_entry("col2", 2, 32'h1833_4891, 2);
        expect_entry("col3", 0, 32'h0000_0021, 4);
        check("col_new_stim", 64'(stim_o), 64'hDEAD_BEEF);
        check("col_new_idx",  64'(idx_o), 64'd1);
        check("col_new_upd",  64'(stim_upd_o), 64'd1);

        // Asynchronous reset mid-cycle while playing entry 1
        #2 rst_i = 1'b1;
        #1;
        check("arst_stim", 64'(stim_o), 64'd0);
        check("arst_busy", 64'(busy_o), 64'd0);
        check("arst_idx",  64'(idx_o), 64'd0);
        check("arst_upd",  64'(stim_upd_o), 64'd0);
        step();
        rst_i = 1'b0;
        check("arst_hold_busy", 64'(busy_o), 64'd0);

        // Replay after reset: table retained
        start_play(3, 1'b0);
        expect_entry("rp0", 0, 32'h0000_0021, 4);
        expect_entry("rp1", 1, 32'hDEAD_BEEF, 6);
        expect_entry("rp2", 2, 32'h1833_4891, 2);
        check("rp_done", 64'(done_o), 64'd1);
        check("rp_busy", 64'(busy_o), 64'd0);
        step();

        // Full table, len_i > DEPTH clamps to 16; entry 5 has hold 0 (one cycle)
        for (int i = 0; i < D; i++) wr(i, 32'hA000_0000 + 32'(i) * 32'h111, (i == 5) ? 0 : 2);
        start_play(20, 1'b0);
        for (int i = 0; i < D; i++)
            expect_entry("full", i, 32'hA000_0000 + 32'(i) * 32'h111, (i == 5) ? 1 : 2);
        check("full_done", 64'(done_o), 64'd1);
        check("full_idx",  64'(idx_o), 64'd15);
        check("full_stim", 64'(stim_o), 64'hA000_0FFF);
        check("full_busy", 64'(busy_o), 64'd0);
        step();
        check("full_done2", 64'(done_o), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
